// File: rtl/tone_pkg.sv
// Shared definitions for the tone player.
// Holds the FSM state type, the special step codes, the note half-period
// table (C5..B5 for a 100 MHz clock) and the default melody.
// No ports; import with `import tone_pkg::*;`.
package tone_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] END  = 4'd15;

  // Half-period in clock cycles at 100 MHz: round(100e6 / (2 * f_note)).
  // Codes 0 and 13..15 are not notes and carry 0.
  localparam int unsigned NOTE_HP [16] = '{
    0,       // 0  rest
    95557,   // 1  C5
    90194,   // 2  C#5
    85131,   // 3  D5
    80353,   // 4  D#5
    75843,   // 5  E5
    71586,   // 6  F5
    67568,   // 7  F#5
    63776,   // 8  G5
    60197,   // 9  G#5
    56818,   // 10 A5
    53629,   // 11 A#5
    50619,   // 12 B5
    0,       // 13 rest
    0,       // 14 rest
    0        // 15 end marker
  };

  // 16 steps, step i at bits [6i+5:6i] = {code, len}. Listed step 15 down to 0:
  // a rising scale, a short rest, then a falling scale ending on a long C5.
  localparam logic [95:0] DEFAULT_MELODY = {
    6'b111100, 6'b000111, 6'b001100, 6'b010100,
    6'b011000, 6'b100000, 6'b101000, 6'b110001,
    6'b000000, 6'b110001, 6'b101000, 6'b100000,
    6'b011000, 6'b010100, 6'b001100, 6'b000100
  };

  function automatic logic is_note(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd12);
  endfunction

endpackage

// File: rtl/tone_rom.sv
// Combinational lookup from a step code to the effective tone half-period,
// i.e. NOTE_HP[code] >> DIV_SHIFT, never less than 1 so the tone counter
// always has a valid terminal count.
// Ports:
//   code  in  4      step code
//   hp    out DIV_W  effective half-period in clock cycles
module tone_rom
  import tone_pkg::*;
#(
  parameter int DIV_W     = 18,
  parameter int DIV_SHIFT = 0
) (
  input  logic [3:0]       code,
  output logic [DIV_W-1:0] hp
);

  logic [DIV_W-1:0] hp_tab [16];

  // The table is fully elaborated from constants, so it folds to plain logic.
  for (genvar gi = 0; gi < 16; gi++) begin : g_tab
    localparam int unsigned SHIFTED = NOTE_HP[gi] >> DIV_SHIFT;
    localparam logic [DIV_W-1:0] HP_EFF = (SHIFTED == 0) ? DIV_W'(1) : DIV_W'(SHIFTED);
    assign hp_tab[gi] = HP_EFF;
  end

  assign hp = hp_tab[code];

endmodule

// File: rtl/tone_player.sv
// Melody sequencer driving a square-wave buzzer.
// Walks a fixed melody of {code, len} steps; each step lasts (len+1) beats,
// the last GAP_CYC cycles of which are silent for articulation.
// Ports:
//   clk    in  1       system clock
//   rst    in  1       synchronous reset, active-high
//   start  in  1       begin playback from step 0 (ignored while busy)
//   stop   in  1       abort playback (wins over start)
//   loop   in  1       restart at step 0 after the last step
//   spek   out 1       buzzer drive
//   busy   out 1       high while playing
//   step   out SEQ_AW  index of the step playing
//   done   out 1       one-cycle pulse on normal completion
module tone_player
  import tone_pkg::*;
#(
  parameter int DIV_W     = 18,
  parameter int DIV_SHIFT = 0,
  parameter int BEAT_CYC  = 25_000_000,
  parameter int GAP_CYC   = 2_500_000,
  parameter int SEQ_LEN   = 16,
  parameter int SEQ_AW    = 4,
  parameter logic [6*SEQ_LEN-1:0] MELODY = (6*SEQ_LEN)'(DEFAULT_MELODY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic              spek,
  output logic              busy,
  output logic [SEQ_AW-1:0] step,
  output logic              done
);

  // Wide enough to count a full four-beat step.
  localparam int DUR_W = $clog2(4 * BEAT_CYC + 1);

  logic [3:0] code_tab [SEQ_LEN];
  logic [1:0] len_tab  [SEQ_LEN];

  for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_melody
    assign code_tab[gi] = MELODY[6*gi+2 +: 4];
    assign len_tab[gi]  = MELODY[6*gi   +: 2];
  end

  state_t            state_reg;
  logic [DIV_W-1:0]  tone_cnt_reg;
  logic [DUR_W-1:0]  dur_reg;
  logic [SEQ_AW-1:0] step_reg;
  logic              spek_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [3:0]        cur_code;
  logic [1:0]        cur_len;
  logic [DIV_W-1:0]  cur_hp;
  logic [DUR_W-1:0]  play_last;
  logic [DUR_W-1:0]  step_last;
  logic [SEQ_AW-1:0] step_inc;
  logic              is_last;
  logic              melody_end;
  logic              step_end;

  tone_rom #(
    .DIV_W     (DIV_W),
    .DIV_SHIFT (DIV_SHIFT)
  ) u_rom (
    .code (cur_code),
    .hp   (cur_hp)
  );

  always_comb begin
    cur_code  = code_tab[step_reg];
    cur_len   = len_tab[step_reg];
    // The duration counter runs across the whole step: PLAY ends at
    // play_last, GAP ends at step_last.
    play_last = DUR_W'((int'(cur_len) + 1) * BEAT_CYC - GAP_CYC - 1);
    step_last = DUR_W'((int'(cur_len) + 1) * BEAT_CYC - 1);
    step_inc  = step_reg + SEQ_AW'(1);
    is_last   = (step_reg == SEQ_AW'(SEQ_LEN - 1));
    // is_last guards the lookup so the table is never read past its end.
    melody_end = is_last || (code_tab[step_inc] == END);
    // With no gap the step ends straight out of PLAY.
    step_end = ((state_reg == S_GAP) && (dur_reg == step_last)) ||
               ((GAP_CYC == 0) && (state_reg == S_PLAY) && (dur_reg == play_last));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      tone_cnt_reg <= '0;
      dur_reg      <= '0;
      step_reg     <= '0;
      spek_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tone_cnt_reg <= '0;
          dur_reg      <= '0;
          step_reg     <= '0;
          spek_reg     <= 1'b0;
          busy_reg     <= 1'b0;
          if (start && !stop) begin
            if (code_tab[0] == END) begin
              // Empty melody: report completion without playing anything.
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_PLAY;
              busy_reg  <= 1'b1;
            end
          end
        end

        S_PLAY, S_GAP: begin
          if (stop) begin
            state_reg    <= S_IDLE;
            tone_cnt_reg <= '0;
            dur_reg      <= '0;
            step_reg     <= '0;
            spek_reg     <= 1'b0;
            busy_reg     <= 1'b0;
          end else if (step_end) begin
            // Every step starts silent with fresh counters.
            tone_cnt_reg <= '0;
            dur_reg      <= '0;
            spek_reg     <= 1'b0;
            if (!melody_end) begin
              state_reg <= S_PLAY;
              step_reg  <= step_inc;
            end else if (loop) begin
              state_reg <= S_PLAY;
              step_reg  <= '0;
            end else begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else if (state_reg == S_GAP) begin
            dur_reg <= dur_reg + DUR_W'(1);
          end else if (dur_reg == play_last) begin
            state_reg    <= S_GAP;
            dur_reg      <= dur_reg + DUR_W'(1);
            tone_cnt_reg <= '0;
            spek_reg     <= 1'b0;
          end else begin
            dur_reg <= dur_reg + DUR_W'(1);
            if (is_note(cur_code)) begin
              if (tone_cnt_reg == cur_hp - DIV_W'(1)) begin
                tone_cnt_reg <= '0;
                spek_reg     <= ~spek_reg;
              end else begin
                tone_cnt_reg <= tone_cnt_reg + DIV_W'(1);
              end
            end else begin
              tone_cnt_reg <= '0;
              spek_reg     <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          step_reg  <= '0;
          spek_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign spek = spek_reg;
  assign busy = busy_reg;
  assign step = step_reg;
  assign done = done_reg;

endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 Parameter DIV_W, default 18: width of the tone half-period counter.
REQ-002 Parameter DIV_SHIFT, default 0: effective half-period = NOTE_HP[code] >> DIV_SHIFT, floored at 1.
REQ-003 Parameter BEAT_CYC, default 25_000_000: clock cycles per beat.
REQ-004 Parameter GAP_CYC, default 2_500_000: silent articulation cycles at the end of each step; must be < BEAT_CYC.
REQ-005 Parameter SEQ_LEN, default 16, and SEQ_AW, default 4: melody steps and step index width.
REQ-006 Parameter MELODY, default DEFAULT_MELODY: SEQ_LEN x 6-bit vector, step i at bits [6i+5:6i], {code[3:0], len[1:0]}.
REQ-007 clk  in  1  system clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous reset, active-high.
REQ-009 start  in  1  one-cycle request to begin playback from step 0.
REQ-010 stop  in  1  abort playback.
REQ-011 loop  in  1  1 = restart at step 0 after the last step; sampled at end of the last step.
REQ-012 spek  out  1  square-wave buzzer drive.
REQ-013 busy  out  1  high while playing.
REQ-014 step  out  SEQ_AW  index of the step currently playing.
REQ-015 done  out  1  one-cycle pulse on normal (non-looped, non-stopped) completion.

Function
REQ-016 FSM states: IDLE, PLAY, GAP, DONE; all outputs registered.
REQ-017 IDLE with start=1 and stop=0: next cycle PLAY, busy=1, step=0, tone and duration counters cleared, spek=0.
REQ-018 start while busy is ignored; stop and start in the same cycle: stop wins.
REQ-019 Step codes: 0 and 13-14 = rest (spek held 0); 1-12 = note, half-period from NOTE_HP; 15 = end marker (not played, no cycles consumed).
REQ-020 Step duration (len+1)*BEAT_CYC cycles: PLAY for (len+1)*BEAT_CYC-GAP_CYC cycles, then GAP for GAP_CYC cycles with spek=0.
REQ-021 In PLAY on a note, the tone counter counts 0..hp-1; at hp-1 it clears and spek toggles, so the first rising edge of spek occurs hp cycles after PLAY entry.
REQ-022 Every step starts with spek=0 and the tone counter at 0.
REQ-023 End of GAP: if step = SEQ_LEN-1 or the next step code is 15, the melody ends; otherwise step increments and the FSM re-enters PLAY.
REQ-024 Melody end with loop=1: step=0, PLAY, busy stays 1, no done pulse.
REQ-025 Melody end with loop=0: DONE for one cycle with done=1, busy=0, spek=0; then IDLE.
REQ-026 Step 0 code 15 on start: go directly to DONE (done pulse, no sound).
REQ-027 stop while busy: next cycle IDLE, spek=0, busy=0, step=0, no done pulse.
REQ-028 Counters saturate-free: the duration counter is wide enough for 4*BEAT_CYC; the tone counter is DIV_W bits, and NOTE_HP entries must fit DIV_W.

Reset
REQ-029 rst=1 at any cycle, including mid-note: next cycle state IDLE, spek=0, busy=0, step=0, done=0, all counters 0.
REQ-030 start during rst is ignored.

Structure
REQ-031 Shared package tone_pkg holds the state enum, the code constants (REST=0, END=15), NOTE_HP[0:15] (C5..B5 at 100 MHz, code 1 = 95557) and DEFAULT_MELODY.
REQ-032 One sub-module tone_rom: combinational code + DIV_SHIFT -> effective half-period lookup; FSM and counters in tone_player.

Verification (bench parameters DIV_SHIFT=12, BEAT_CYC=64, GAP_CYC=2, SEQ_LEN=4)
REQ-033 MELODY step0={1,0}, step1={15,x}; pulse start -> busy=1 next cycle, spek rises at +23 and falls at +46 cycles, 0 during GAP, done=1 exactly 64 cycles after PLAY entry, then busy=0.
REQ-034 step0={0,1}, step1={1,0}, step2={15,x} -> spek=0 for 128 cycles while step=0, then step=1 and spek toggles every 23 cycles.
REQ-035 Two-step note melody with loop=1 -> after step 1, step returns to 0, busy stays 1, done never pulses; drop loop -> done after the next pass.
REQ-036 stop 30 cycles into a note -> next cycle spek=0, busy=0, step=0, no done; start+stop in the same cycle from IDLE -> stays IDLE.
REQ-037 start pulse while busy -> step and counters unaffected; rst at cycle 40 of PLAY -> next cycle all outputs 0, state IDLE.
